// File: rtl/regarb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regarb_pkg
// Description : Shared widths, FIFO entry type and FSM state encoding for the
//               register file write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package regarb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     value;
    } regarb_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        STARVE = 2'd2
    } regarb_state_t;

    function automatic logic [NUM_REGS-1:0] dest_onehot(input logic [REG_ADDR_W-1:0] dest);
        dest_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << dest;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regarb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : regarb_fifo
// Description : Circular buffer for multi-cycle results with occupancy count
//               and a registered pending-destination mask.
//               REGARB_ZERO_DROP_EN: entries for register 0 never mark the mask.
// Revision    : 1.0 - initial release
// ============================================================================
module regarb_fifo
    import regarb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [REG_ADDR_W-1:0]      i_dest,
    input  logic [DATA_W-1:0]          i_value,
    output logic [REG_ADDR_W-1:0]      o_head_dest,
    output logic [DATA_W-1:0]          o_head_value,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [NUM_REGS-1:0]        o_pending_mask
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    regarb_entry_t        r_mem [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [NUM_REGS-1:0]  r_pending;

    logic [DEPTH-1:0]     w_valid_nxt;
    logic [NUM_REGS-1:0]  w_pending_nxt;
    logic [REG_ADDR_W-1:0] w_slot_dest;

    assign o_head_dest    = r_mem[r_rd_ptr].dest;
    assign o_head_value   = r_mem[r_rd_ptr].value;
    assign o_full         = (r_count == c_CNT_W'(DEPTH));
    assign o_empty        = (r_count == '0);
    assign o_count        = r_count;
    assign o_pending_mask = r_pending;

    // Mask is rebuilt from the post-edge contents so it tracks push and pop exactly.
    always_comb begin
        w_valid_nxt   = r_valid;
        w_pending_nxt = '0;
        w_slot_dest   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_pop && (r_rd_ptr == c_PTR_W'(i)))
                w_valid_nxt[i] = 1'b0;
            if (i_push && (r_wr_ptr == c_PTR_W'(i)))
                w_valid_nxt[i] = 1'b1;
            w_slot_dest = (i_push && (r_wr_ptr == c_PTR_W'(i))) ? i_dest : r_mem[i].dest;
`ifdef REGARB_ZERO_DROP_EN
            if (w_valid_nxt[i] && (w_slot_dest != '0))
                w_pending_nxt = w_pending_nxt | dest_onehot(w_slot_dest);
`else
            if (w_valid_nxt[i])
                w_pending_nxt = w_pending_nxt | dest_onehot(w_slot_dest);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr_ptr] <= '{dest: i_dest, value: i_value};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_valid   <= '0;
            r_pending <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_valid   <= w_valid_nxt;
            r_pending <= w_pending_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the register file write port between the writeback
//               stage (always wins) and buffered multi-cycle results, with a
//               starvation stall request. Option: REGARB_ZERO_DROP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
    import regarb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wb_valid,
    input  logic [4:0]                    wb_dest,
    input  logic [31:0]                   wb_value,
    input  logic                          mc_valid,
    output logic                          mc_ready,
    input  logic [4:0]                    mc_dest,
    input  logic [31:0]                   mc_value,
    output logic                          rf_write_en,
    output logic [4:0]                    rf_dest,
    output logic [31:0]                   rf_write_value,
    output logic                          stall_req,
    output logic [31:0]                   pending_mask,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err_protocol
);

    localparam int          c_CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0]  c_MAX_WAIT = 8'(MAX_WAIT);
    localparam logic [c_CNT_W-1:0] c_ONE = c_CNT_W'(1);

    regarb_state_t          r_state;
    regarb_state_t          w_state_nxt;
    logic                   r_alive;
    logic [7:0]             r_wait;
    logic [7:0]             w_wait_nxt;
    logic                   r_stall;
    logic                   r_err;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_last_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [REG_ADDR_W-1:0]  w_head_dest;
    logic [DATA_W-1:0]      w_head_value;

    // r_alive keeps mc_ready low until the first edge after reset release.
    assign mc_ready     = r_alive && !w_full;
    assign w_push       = mc_valid && mc_ready;
    assign stall_req    = r_stall;
    assign err_protocol = r_err;

    regarb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_push         (w_push),
        .i_pop          (w_pop),
        .i_dest         (mc_dest),
        .i_value        (mc_value),
        .o_head_dest    (w_head_dest),
        .o_head_value   (w_head_value),
        .o_full         (w_full),
        .o_empty        (w_empty),
        .o_count        (fifo_count),
        .o_pending_mask (pending_mask)
    );

    always_comb begin
        w_pop          = 1'b0;
        rf_write_en    = 1'b0;
        rf_dest        = '0;
        rf_write_value = '0;
        if (wb_valid) begin
            rf_write_en    = 1'b1;
            rf_dest        = wb_dest;
            rf_write_value = wb_value;
        end else if (!w_empty) begin
            w_pop          = 1'b1;
            rf_write_en    = 1'b1;
            rf_dest        = w_head_dest;
            rf_write_value = w_head_value;
        end
`ifdef REGARB_ZERO_DROP_EN
        if (rf_dest == '0)
            rf_write_en = 1'b0;
`endif
    end

    always_comb begin
        w_wait_nxt = r_wait;
        if (w_empty || w_pop)
            w_wait_nxt = '0;
        else if (wb_valid && (r_wait < c_MAX_WAIT))
            w_wait_nxt = r_wait + 8'd1;
    end

    assign w_last_pop = w_pop && (fifo_count == c_ONE) && !w_push;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_push)
                    w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_last_pop)
                    w_state_nxt = IDLE;
                else if (!w_pop && (w_wait_nxt == c_MAX_WAIT))
                    w_state_nxt = STARVE;
            end
            STARVE: begin
                if (w_pop)
                    w_state_nxt = w_last_pop ? IDLE : DRAIN;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_alive <= 1'b0;
            r_wait  <= '0;
            r_stall <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_alive <= 1'b1;
            r_wait  <= w_wait_nxt;
            r_stall <= (w_state_nxt == STARVE);
            if (wb_valid && r_stall)
                r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Randomised self-checking bench with a queue-based reference
//               model of the write arbiter. Honours REGARB_ZERO_DROP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int DEPTH = 4;
    localparam int MAXW  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_dest = '0;
    logic [31:0] wb_value = '0;
    logic        mc_valid = 1'b0;
    logic        mc_ready;
    logic [4:0]  mc_dest = '0;
    logic [31:0] mc_value = '0;
    logic        rf_write_en;
    logic [4:0]  rf_dest;
    logic [31:0] rf_write_value;
    logic        stall_req;
    logic [31:0] pending_mask;
    logic [$clog2(DEPTH):0] fifo_count;
    logic        err_protocol;

    regfile_write_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .MAX_WAIT   (MAXW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb_valid       (wb_valid),
        .wb_dest        (wb_dest),
        .wb_value       (wb_value),
        .mc_valid       (mc_valid),
        .mc_ready       (mc_ready),
        .mc_dest        (mc_dest),
        .mc_value       (mc_value),
        .rf_write_en    (rf_write_en),
        .rf_dest        (rf_dest),
        .rf_write_value (rf_write_value),
        .stall_req      (stall_req),
        .pending_mask   (pending_mask),
        .fifo_count     (fifo_count),
        .err_protocol   (err_protocol)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] value;
    } ent_t;

    ent_t q[$];
    int   m_wait  = 0;
    bit   m_stall = 1'b0;
    bit   m_err   = 1'b0;
    bit   m_alive = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, compare before the next posedge,
    // then advance the model to what that posedge must produce.
    task automatic step(input bit rst, input bit wv, input logic [4:0] wd, input logic [31:0] wval,
                        input bit mv, input logic [4:0] md, input logic [31:0] mval);
        bit          e_en, e_ready, pop, push, was_empty;
        logic [4:0]  e_dest;
        logic [31:0] e_val, e_mask;
        @(negedge clk);
        rst_n    = rst;
        wb_valid = wv;  wb_dest = wd;  wb_value = mval ^ wval ^ mval;
        mc_valid = mv;  mc_dest = md;  mc_value = mval;
        #1;
        if (!rst) begin
            q.delete();
            m_wait = 0; m_stall = 1'b0; m_err = 1'b0; m_alive = 1'b0;
        end
        e_ready = m_alive && (q.size() < DEPTH);
        pop = 1'b0; e_en = 1'b0; e_dest = '0; e_val = '0;
        if (wv) begin
            e_en = 1'b1; e_dest = wd; e_val = wval;
        end else if (q.size() > 0) begin
            e_en = 1'b1; e_dest = q[0].dest; e_val = q[0].value; pop = 1'b1;
        end
        e_mask = '0;
        foreach (q[i]) begin
`ifdef REGARB_ZERO_DROP_EN
            if (q[i].dest != 5'd0) e_mask[q[i].dest] = 1'b1;
`else
            e_mask[q[i].dest] = 1'b1;
`endif
        end
`ifdef REGARB_ZERO_DROP_EN
        if (e_dest == 5'd0) e_en = 1'b0;
`endif
        check("rf_write_en",    32'(rf_write_en),    32'(e_en));
        check("rf_dest",        32'(rf_dest),        32'(e_dest));
        check("rf_write_value", rf_write_value,      e_val);
        check("mc_ready",       32'(mc_ready),       32'(e_ready));
        check("fifo_count",     32'(fifo_count),     32'(q.size()));
        check("stall_req",      32'(stall_req),      32'(m_stall));
        check("pending_mask",   pending_mask,        e_mask);
        check("err_protocol",   32'(err_protocol),   32'(m_err));
        if (rst) begin
            push      = mv && e_ready;
            was_empty = (q.size() == 0);
            if (wv && m_stall) m_err = 1'b1;
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{dest: md, value: mval});
            if (was_empty || pop) m_wait = 0;
            else if (m_wait < MAXW) m_wait++;
            if (pop) m_stall = 1'b0;
            else if (m_wait == MAXW) m_stall = 1'b1;
            m_alive = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pwb;
        // reset and idle
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step(0, 1, 5'd7, 32'h1234, 1, 5'd3, 32'd9);
        repeat (3) step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

        // single push drains on the next idle cycle
        step(1, 0, 5'd0, 32'd0, 1, 5'd5, 32'hA5);
        repeat (3) step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

        // fill under continuous writeback, starve, protocol error, then drain
        for (int i = 1; i <= 4; i++)
            step(1, 1, 5'(10 + i), $urandom, 1, 5'(i), 32'h100 + 32'(i));
        repeat (6) step(1, 1, 5'(i_rand5()), $urandom, 0, 5'd0, 32'd0);
        step(1, 0, 5'd0, 32'd0, 1, 5'd9, 32'h900);
        step(1, 1, 5'd2, 32'h22, 1, 5'd9, 32'h900);
        repeat (6) step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

        // reset pulse clears the error flag
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

        // write to register 0 from both sources
        step(1, 1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
        repeat (2) step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

        // randomised traffic with shifting writeback pressure and rare resets
        for (int n = 0; n < 3000; n++) begin
            pwb = (n / 250) % 4;
            step(($urandom_range(0, 399) != 0),
                 ($urandom_range(0, 3) < pwb) || (pwb == 3),
                 5'($urandom), $urandom,
                 ($urandom_range(0, 1) == 1), 5'($urandom), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    function automatic logic [4:0] i_rand5();
        return 5'($urandom);
    endfunction

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between the in-order pipeline writeback stage and a multi-cycle result source (MUL/DIV or load-return unit). Pipeline writes are granted unconditionally in the same cycle. Multi-cycle results are buffered in a small FIFO and drained on idle writeback cycles. A starvation guard requests a one-bubble pipeline stall, and a pending-destination mask feeds hazard detection. The block sits between the writeback stage, the multi-cycle unit and the register file write inputs.

## Interface
- FIFO_DEPTH, 4, multi-cycle result buffer depth; power of two, ≥2
- MAX_WAIT, 8, consecutive lost arbitrations before a stall is requested; 1..255
- clk  in  1  clock; all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- wb_valid  in  1  pipeline writeback request; never back-pressured
- wb_dest  in  5  pipeline destination register
- wb_value  in  32  pipeline write data
- mc_valid  in  1  multi-cycle result valid
- mc_ready  out  1  arbiter can accept a multi-cycle result
- mc_dest  in  5  multi-cycle destination register
- mc_value  in  32  multi-cycle write data
- rf_write_en  out  1  register file write enable
- rf_dest  out  5  register file destination
- rf_write_value  out  32  register file write data
- stall_req  out  1  registered request for the pipeline to insert a writeback bubble
- pending_mask  out  32  bit r set while any buffered entry targets register r
- fifo_count  out  $clog2(FIFO_DEPTH)+1  buffered entries
- err_protocol  out  1  sticky; set when wb_valid=1 while stall_req=1

## Operation
- Grant, combinational: if wb_valid, the write port carries wb_*. Otherwise, if the FIFO is non-empty, it carries the FIFO head and pops it. Otherwise rf_write_en=0, and rf_dest and rf_write_value are 0.
- mc_ready = !full. It is computed from registered state only, so there is no combinational path from mc_valid to mc_ready. A push occurs when mc_valid && mc_ready.
- A push and a pop in the same cycle are both legal. The count is unchanged and the pointers wrap modulo FIFO_DEPTH.
- A push never bypasses into the same-cycle write port. An empty FIFO stays empty for the grant in the push cycle.
- FIFO entries drain strictly in arrival order. Ordering between the two sources is the issuer's responsibility; pending_mask exists to support this.
- pending_mask is the registered OR of one-hot(dest) over all valid entries. It is updated at every push/pop edge.
- Wait counter (8 bits):
  - clears when the FIFO is empty or a pop occurs;
  - increments when the FIFO is non-empty and wb_valid=1;
  - saturates at MAX_WAIT.
- stall_req is set at the edge where the counter reaches MAX_WAIT. It clears at the edge of the cycle in which the head pops.
- If wb_valid=1 while stall_req=1, the pipeline still wins the port and err_protocol is set until reset.
- States: IDLE (empty), DRAIN (non-empty, counter<MAX_WAIT), STARVE (stall_req=1).
  - IDLE→DRAIN on push without pop.
  - DRAIN→IDLE when the last entry pops with no push.
  - DRAIN→STARVE when the counter reaches MAX_WAIT.
  - STARVE→DRAIN on pop while entries remain and no push would leave it empty; otherwise STARVE→IDLE.

## Timing
- Reset (rst_n low, asynchronous):
  - FIFO empty, counter 0, state IDLE;
  - stall_req=0, pending_mask=0, fifo_count=0, err_protocol=0, mc_ready=0.
  - mc_ready rises in the first cycle after rst_n deasserts.
- A reset mid-operation discards buffered entries. The rf_* outputs follow wb_* combinationally even while in reset.
- Pipeline write latency is 0 cycles: rf_* are valid in the same cycle, and the register file captures on the negedge.
- A multi-cycle result accepted at edge N is written at the earliest in cycle N+1.
- With continuous wb_valid, stall_req asserts MAX_WAIT cycles after the FIFO becomes non-empty. The head drains in the first cycle where wb_valid=0.

## Configuration
- REGARB_ZERO_DROP_EN defined:
  - writes with dest==0 from either source produce rf_write_en=0;
  - an mc entry with dest 0 is still pushed and popped but never sets pending_mask bit 0.
- REGARB_ZERO_DROP_EN undefined: register 0 is written like any other register.

## Structure
- Package regarb_pkg holds:
  - REG_ADDR_W=5 and DATA_W=32;
  - the typedef regarb_entry_t {dest, value};
  - the state enum regarb_state_t {IDLE, DRAIN, STARVE}.
- Sub-module regarb_fifo holds the circular buffer with pointers, count, full/empty and pending_mask generation. The top level holds the grant logic, wait counter, FSM and error flag.

## Test plan
- Reset, then idle with no requests → rf_write_en=0, mc_ready=1, fifo_count=0.
- mc push (dest 5, value 0xA5) with wb_valid=0 → next cycle rf_write_en=1, rf_dest=5, rf_write_value=0xA5; pending_mask bit 5 is set for one cycle and then clears.
- wb_valid held high, four mc pushes (dest 1..4) → mc_ready=0 at count 4; stall_req=1 MAX_WAIT=8 cycles after the first push; after wb drops, entries drain in order 1,2,3,4 on consecutive cycles.
- Full FIFO, a pop and mc_valid=1 in the same cycle → the push is refused that cycle and accepted next cycle; the count goes 4→3→4.
- wb_valid=1 during stall_req=1 → wb is written and err_protocol=1 until rst_n pulses low.
- With REGARB_ZERO_DROP_EN, wb write to dest 0 → rf_write_en=0; without the macro → rf_write_en=1.
